// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit blocks: FSM state encoding
// and the default bit period for the 100 MHz build.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with extra-MSB pointers; a push
// into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid = !w_empty;
  assign o_full  = w_full;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_rx_fifo.sv
// Mid-bit-sampling UART receiver feeding a FWFT FIFO, with sticky framing and
// overrun errors. Define UART_RX_PARITY_EN to add a parity bit and o_parity_err.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = $clog2(FIFO_DEPTH)
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [FIFO_AW:0]     o_count,
  output logic                 o_frame_err,
  output logic                 o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  input  logic                 i_clr_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 r_rx_meta;
  logic                 r_rx_s;
  uart_state_t          r_state;
  logic [TW-1:0]        r_timer;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_sample;
  logic                 w_push;
  logic                 w_frame_evt;
  logic                 w_ovr_evt;
  logic                 w_full;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
  logic                 w_par_evt;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rxd;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_sample    = (r_timer == T_LAST);
  assign w_frame_evt = (r_state == ST_STOP) && w_sample && !r_rx_s;
`ifdef UART_RX_PARITY_EN
  assign w_par_evt   = (r_state == ST_PARITY) && w_sample &&
                       ((^{r_shift, r_rx_s}) != PARITY_ODD);
  assign w_push      = (r_state == ST_STOP) && w_sample && r_rx_s && !r_par_bad;
`else
  assign w_push      = (r_state == ST_STOP) && w_sample && r_rx_s;
`endif
  // A full FIFO still accepts the word if the consumer pops in the same cycle.
  assign w_ovr_evt   = w_push && w_full && !(i_ready && o_valid);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer   <= '0;
          r_bit_idx <= '0;
          if (!r_rx_s) r_state <= ST_START;
        end
        ST_START: begin
          if (r_timer == T_HALF) begin
            r_timer <= '0;
            r_state <= r_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_sample) begin
            r_timer   <= '0;
            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_sample) begin
            r_timer   <= '0;
            r_par_bad <= w_par_evt;
            r_state   <= ST_STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_sample) begin
            r_timer <= '0;
            r_state <= r_rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_BREAK: begin
          if (r_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky errors: a new event in the same cycle as a clear keeps the bit set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_frame_evt)    r_frame_err <= 1'b1;
      else if (i_clr_err) r_frame_err <= 1'b0;
      if (w_ovr_evt)      r_overrun   <= 1'b1;
      else if (i_clr_err) r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (w_par_evt)      r_parity_err <= 1'b1;
      else if (i_clr_err) r_parity_err <= 1'b0;
`endif
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (i_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_full      (w_full),
    .o_count     (o_count)
  );

  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`endif
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the keyboard UART receiver. It is a mid-bit-sampling asynchronous serial receiver with a configurable bit period and word width. Received words go into a first-word-fall-through FIFO with a valid/ready pop handshake. It reports sticky framing and overrun errors, and sits between an external serial pin (CH559 keyboard, debug host) and the SoC peripheral bus.

Parameters:
CLKS_PER_BIT, 100, CLK cycles per serial bit (>=8); 100 gives 1 Mbaud at 100 MHz
DATA_BITS, 8, data bits per frame (5..9), LSB first
FIFO_DEPTH, 16, FIFO entries; power of two, >=2
FIFO_AW, $clog2(FIFO_DEPTH), derived; do not override

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
i_rxd  in  1  serial input, idle high, asynchronous to CLK
o_data  out  DATA_BITS  FIFO head word; valid only while o_valid=1
o_valid  out  1  FIFO not empty
i_ready  in  1  consumer accepts head; pop occurs on o_valid&i_ready
o_count  out  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH
o_frame_err  out  1  sticky: a stop bit was sampled low
o_overrun  out  1  sticky: a word was dropped because the FIFO was full
i_clr_err  in  1  one-cycle pulse clears both sticky errors
o_busy  out  1  receiver FSM not in IDLE

Behaviour:
- Reset (async assert, sync release via CLK): FSM=IDLE, FIFO pointers=0, o_valid=0, o_count=0, o_data=0, o_frame_err=0, o_overrun=0, o_busy=0. Synchroniser flops reset to 1.
- Input: 2-FF synchroniser on i_rxd; all decisions use the synchronised value rx_s.
- Bit counter: timer counts 0..CLKS_PER_BIT-1; bit index counts 0..DATA_BITS-1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s==0, go to START and clear the timer.
  - START: at timer==CLKS_PER_BIT/2-1, re-sample. If rx_s==1 (glitch), return to IDLE with no error. Otherwise go to DATA and clear the timer.
  - DATA: at each timer==CLKS_PER_BIT-1, shift rx_s into the shift register MSB side (LSB first on the wire). After DATA_BITS samples, go to STOP.
  - STOP: at timer==CLKS_PER_BIT-1, sample. If 1, push the word and go to IDLE. If 0, set o_frame_err, discard the word, and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line therefore yields exactly one frame error, not repeated frames.
- Latency: the pushed word appears on o_data with o_valid=1 one cycle after the stop-bit sample cycle. From start-bit falling edge at the pin, total latency is about (DATA_BITS+1.5)*CLKS_PER_BIT + 3 cycles.
- FIFO:
  - Registered read/write pointers with FIFO_AW+1 bits, wrapping modulo 2*FIFO_DEPTH.
  - empty when pointers are equal; full when the MSBs differ and the low bits are equal.
  - o_data is driven from the head entry combinationally off storage (fall-through).
- Push when full:
  - Without a same-cycle pop: the word is dropped, o_overrun is set, and FIFO contents are unchanged.
  - With a same-cycle pop: both occur, o_count stays FIFO_DEPTH, and no overrun.
- Pop when empty: ignored, and o_count does not underflow.
- Simultaneous push and pop when not full and not empty: o_count unchanged.
- Sticky errors: if i_clr_err coincides with a new error event, the set wins (the bit stays 1).
- o_busy = (FSM != IDLE).
- RST asserted mid-frame: the partial word is lost, the FIFO is flushed, and everything returns to reset values immediately.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - adds a PARITY state between DATA and STOP, plus parameter PARITY_ODD (default 0 = even) and output o_parity_err (sticky, cleared by i_clr_err, reset 0).
  - A parity mismatch sets o_parity_err and discards the word; the FSM still proceeds to STOP.
- Undefined: no PARITY state, no o_parity_err port; frame = start + DATA_BITS + stop.

Decomposition:
- Shared package uart_pkg: FSM state encoding constants (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK) and default CLKS_PER_BIT for the 100 MHz build.
- One sub-module is natural: sync_fifo_fwft (parameters WIDTH, DEPTH). It carries push/pop/full/empty/count and is reusable by a later uart_tx_fifo.

Test Plan:
1. CLKS_PER_BIT=100, send 0xA5 (8N1), i_ready=0 -> o_valid rises ~953 cycles after the start edge, o_data=0xA5, o_count=1, no errors; i_ready pulse -> o_valid=0, o_count=0.
2. Send 17 words 0x00..0x10 with i_ready=0, FIFO_DEPTH=16 -> o_count=16, o_overrun=1; drain to read 0x00..0x0F in order, and 0x10 is absent.
3. Send 0x3C with the stop bit driven low, then the line held low for 30 bit times, then high -> o_frame_err=1 exactly once, o_count=0, FSM returns to IDLE; the next 0x55 is received correctly.
4. Low glitch of 20 cycles on an idle line -> no push, no error, o_busy returns to 0 by the half-bit check.
5. FIFO full with i_ready=1 held on the cycle a new word pushes -> o_count stays 16, o_overrun stays 0, read order preserved.
6. Assert RST at bit 4 of a frame while o_count=3 -> all outputs zero immediately; after release, a fresh 0x81 is received correctly. With UART_RX_PARITY_EN (even parity), 0x81 with parity bit 1 -> o_parity_err=1 and the word is discarded.
